// File: rtl/matricula_validator.sv
// rtl/matricula_validator.sv - licence plate assembler, format checker and whitelist matcher
// Collects six characters, checks pair format, matches against a programmable whitelist.
module matricula_validator #(
  parameter int NPLATES = 4,
  parameter int TIMEOUT = 1000,
  localparam int AW = $clog2(NPLATES)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    CharIn,
  input  logic          CharVal,
  input  logic          Clear,
  input  logic          ProgEn,
  input  logic [AW-1:0] ProgAddr,
  input  logic [47:0]   ProgData,
  output logic          MatrVal,
  output logic          MatrInv,
  output logic          Erro,
  output logic          Busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    chr_q [6];
  logic [7:0]    chr_d [6];
  logic          val_q, val_d, inv_q, inv_d, erro_q, erro_d, busy_q, busy_d;

  logic [47:0]        wl_q [NPLATES];
  logic [NPLATES-1:0] wl_vld_q;

  logic [47:0] plate;
  logic [2:0]  pair_let, pair_dig;
  logic        well_formed, match;

  function automatic logic is_let(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  assign plate = {chr_q[0], chr_q[1], chr_q[2], chr_q[3], chr_q[4], chr_q[5]};

  always_comb begin
    pair_let = '0;
    pair_dig = '0;
    match    = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pair_let[p] = is_let(chr_q[2*p]) && is_let(chr_q[2*p+1]);
      pair_dig[p] = is_dig(chr_q[2*p]) && is_dig(chr_q[2*p+1]);
    end
    for (int i = 0; i < NPLATES; i++) begin
      if (wl_vld_q[i] && (wl_q[i] == plate)) match = 1'b1;
    end
    well_formed = (&(pair_let | pair_dig)) && (|pair_let) && (|pair_dig);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    val_d   = 1'b0;
    inv_d   = 1'b0;
    erro_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CharVal) begin
          chr_d[0] = CharIn;
          idx_d    = 3'd1;
          cnt_d    = '0;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (Clear) begin
          state_d = IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end else if (CharVal) begin
          chr_d[idx_q] = CharIn;
          cnt_d        = '0;
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = COMPARE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          // Saturating idle counter; the edge it reaches TIMEOUT is the Erro edge.
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            erro_d  = 1'b1;
          end
        end
      end
      COMPARE: begin
        state_d = IDLE;
        if (!Clear) begin
          val_d = well_formed && match;
          inv_d = !(well_formed && match);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      inv_q   <= 1'b0;
      erro_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 6; i++) chr_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      inv_q   <= inv_d;
      erro_q  <= erro_d;
      busy_q  <= busy_d;
      chr_q   <= chr_d;
    end
  end

  // A write on the COMPARE edge lands after the match above was already sampled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wl_vld_q <= '0;
      for (int i = 0; i < NPLATES; i++) wl_q[i] <= 48'h0;
    end else if (ProgEn) begin
      wl_q[ProgAddr]     <= ProgData;
      wl_vld_q[ProgAddr] <= |ProgData;
    end
  end

  assign MatrVal = val_q;
  assign MatrInv = inv_q;
  assign Erro    = erro_q;
  assign Busy    = busy_q;

endmodule

// File: doc/matricula_validator.md
# matricula_validator

Upstream stage of the parking barrier controller. It assembles a 6-character licence plate from a serial character stream, checks the plate format, and compares the plate against a programmable whitelist. It emits a one-cycle `MatrVal` pulse for authorised plates, which the barrier stage consumes to open. Rejected plates raise `MatrInv` instead, and an abandoned entry raises `Erro`.

## Interface
- `NPLATES`, 4: number of whitelist entries; power of 2, at least 2.
- `TIMEOUT`, 1000: idle cycles allowed between characters of a partially entered plate.
- `AW`, log2(NPLATES): whitelist address width (derived).

- `CLK`  in  1  rising-edge clock; all state is updated on it.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CharIn`  in  8  ASCII character.
- `CharVal`  in  1  `CharIn` is valid this cycle; one character is taken per asserted cycle.
- `Clear`  in  1  synchronous abort of the plate being entered.
- `ProgEn`  in  1  write `ProgData` into whitelist entry `ProgAddr`.
- `ProgAddr`  in  AW  whitelist entry index.
- `ProgData`  in  48  plate as 6 ASCII bytes, character 0 in [47:40]; all-zero invalidates the entry.
- `MatrVal`  out  1  one-cycle pulse: plate is well formed and whitelisted.
- `MatrInv`  out  1  one-cycle pulse: plate is malformed or not whitelisted.
- `Erro`  out  1  one-cycle pulse: entry aborted by timeout.
- `Busy`  out  1  high while in COLLECT or COMPARE.

## Operation
- **State machine states:** IDLE, COLLECT, COMPARE.
- **Character intake:**
  - A `CharVal` edge in IDLE stores the character at index 0 and moves the FSM to COLLECT.
  - A `CharVal` edge in COLLECT stores at the current index and increments it.
  - Storing index 5 moves the FSM to COMPARE.
- **Ignored character:** `CharVal` is ignored in COMPARE.
- **Format rule:**
  - The plate is three pairs: (0,1), (2,3), (4,5).
  - A pair is valid when both of its characters are in 'A'–'Z', or both are in '0'–'9'.
  - The plate is well formed when every pair is valid and there is at least one letter pair and at least one digit pair.
  - Examples: "AA00AA" and "00AA00" are well formed; "A0A0A0" and "000000" are not.
- **COMPARE, single cycle:**
  - The plate matches if it equals any valid whitelist entry; all entries are compared in parallel.
  - Well formed and matching gives `MatrVal`=1; otherwise `MatrInv`=1.
  - The FSM then returns to IDLE.
- **Whitelist:**
  - `NPLATES` × 48-bit registers, each with a valid bit.
  - `ProgEn` writes on the clock edge, in any state.
  - Writing nonzero data sets the valid bit; writing zero clears it.
  - COMPARE uses the contents present before the same edge, so a simultaneous write does not affect that result.
- **Clear:**
  - In COLLECT or COMPARE, the FSM goes to IDLE, the index goes to 0, and no pulse is produced.
  - `Clear` has priority over `CharVal` and over the COMPARE result.
  - The whitelist is untouched.
- **Timeout:**
  - The counter reloads to 0 on every accepted character and counts cycles in COLLECT without `CharVal`.
  - When it reaches `TIMEOUT`, the FSM goes to IDLE, the index goes to 0, and `Erro` pulses for one cycle.
  - `Clear` in the same cycle suppresses `Erro`.
- **Outputs:** all outputs are registered, and `MatrVal`, `MatrInv` and `Erro` are mutually exclusive.

## Timing
- **Reset:**
  - Asynchronous; takes effect immediately, mid-plate included.
  - The state becomes IDLE, the index 0, the timeout counter 0, and all whitelist valid bits 0.
  - `MatrVal`, `MatrInv`, `Erro` and `Busy` become 0.
- **Latency:**
  - The 6th character is taken on edge k.
  - The result is registered on edge k+1, and `MatrVal`/`MatrInv` is high from k+1 to k+2.
  - A `CharVal` sampled on edge k+1 is dropped; the next plate can start on edge k+2.
- **Busy:**
  - Rises after the first accepted character.
  - Falls on the edge that registers the result, or on `Clear` or timeout.
- **Timeout timing:** with the last character on edge t, `Erro` is high from edge t+`TIMEOUT` to t+`TIMEOUT`+1.
- **Width rules:**
  - The index is 3 bits and never exceeds 5.
  - The timeout counter is ceil(log2(`TIMEOUT`+1)) bits and saturates.
  - Character comparisons are unsigned 8-bit.
- **Pulse spacing:** at most one result pulse per plate, so two result pulses are always at least 7 cycles apart.

## Test plan
- Program entry 0 = "AA00AA", release reset, send 'A','A','0','0','A','A' on consecutive cycles -> `MatrVal`=1 for exactly 1 cycle, 1 cycle after the 6th character; `MatrInv`=`Erro`=0.
- Entry 0 = "AA00AA" only, send "00AA00" -> `MatrInv` pulse; send "A0A0A0" -> `MatrInv` pulse; no `MatrVal`.
- `TIMEOUT`=8, send 'A','A','0' then stop -> `Erro` pulses 8 cycles after the last character and `Busy`=0; then a full "AA00AA" -> `MatrVal` pulse.
- `Clear` asserted together with the 4th character -> no pulse and `Busy`=0; then write 0 to entry 0 in the same cycle as the COMPARE edge of "AA00AA" -> `MatrVal` still pulses; the repeated plate -> `MatrInv` pulse.
- Drop `RST_N` mid-plate (after 3 characters) and during a `MatrVal` pulse -> all outputs 0 immediately; a whitelisted plate sent after reset -> `MatrInv` pulse, because the table was cleared.
